// File: rtl/isa_test_pkg.sv
// Shared types and defaults for the ISA test sequencer.
// test_cfg_t is sized by DATA_W_DEF, so the top's DATA_W must match it.
package isa_test_pkg;

  localparam int unsigned DATA_W_DEF         = 8;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 1000;

  typedef enum logic [2:0] {
    IDLE,
    SKIP,
    CRST,
    START,
    WAIT,
    CHECK,
    NEXT,
    FIN
  } seq_state_t;

  typedef struct packed {
    logic                  en;
    logic [DATA_W_DEF-1:0] expected;
    logic [DATA_W_DEF-1:0] mask;
  } test_cfg_t;

  function automatic test_cfg_t cfg_default();
    return '{en: 1'b0, expected: '0, mask: '1};
  endfunction

endpackage

// File: rtl/isa_test_watchdog.sv
// Cycle counter bounding how long the sequencer waits for core_done.
module isa_test_watchdog #(
  parameter int unsigned TIMEOUT_W      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired_c
);

  logic [TIMEOUT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!reset)   cnt_q <= '0;
    else if (clr) cnt_q <= '0;
    else if (en)  cnt_q <= cnt_q + TIMEOUT_W'(1);
  end

  // Fires in the enabled cycle whose increment would reach TIMEOUT_CYCLES.
  assign expired_c = en && (cnt_q == TIMEOUT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/isa_test_sequencer.sv
// Runs up to NUM_TESTS directed tests on the ISA core and collects verdicts.
// Optional macro ISA_TEST_STOP_ON_FAIL_EN ends the run at the first failing slot.
module isa_test_sequencer
  import isa_test_pkg::*;
#(
  parameter int unsigned NUM_TESTS      = 8,
  parameter int unsigned DATA_W         = DATA_W_DEF,
  parameter int unsigned TIMEOUT_W      = 16,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int unsigned RST_CYCLES     = 2,
  localparam int unsigned IDX_W = (NUM_TESTS > 1) ? $clog2(NUM_TESTS) : 1,
  localparam int unsigned CNT_W = $clog2(NUM_TESTS + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 go,
  input  logic                 cfg_we,
  input  logic [IDX_W-1:0]     cfg_idx,
  input  logic                 cfg_en,
  input  logic [DATA_W-1:0]    cfg_expected,
  input  logic [DATA_W-1:0]    cfg_mask,
  output logic                 core_reset,
  output logic                 core_start,
  input  logic                 core_done,
  output logic [IDX_W-1:0]     test_idx,
  input  logic [DATA_W-1:0]    obs_data,
  output logic                 busy,
  output logic                 run_done,
  output logic [NUM_TESTS-1:0] pass_vec,
  output logic [NUM_TESTS-1:0] fail_vec,
  output logic [NUM_TESTS-1:0] timeout_vec,
  output logic [CNT_W-1:0]     pass_count,
  output logic [CNT_W-1:0]     fail_count
);

  localparam int unsigned RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

`ifdef ISA_TEST_STOP_ON_FAIL_EN
  localparam seq_state_t FAIL_DEST = FIN;
`else
  localparam seq_state_t FAIL_DEST = NEXT;
`endif

  seq_state_t           state_q, state_d;
  test_cfg_t            cfg_tbl [NUM_TESTS];
  test_cfg_t            cur_cfg_c;
  logic [RC_W-1:0]      rst_cnt_q, rst_cnt_d;
  logic [IDX_W-1:0]     idx_d;
  logic                 core_reset_d, core_start_d, busy_d, run_done_d;
  logic [NUM_TESTS-1:0] pass_vec_d, fail_vec_d, timeout_vec_d;
  logic [CNT_W-1:0]     pass_cnt_d, fail_cnt_d;
  logic                 match_c, last_c, wd_expired_c;

  assign cur_cfg_c = cfg_tbl[test_idx];
  assign match_c   = ((obs_data ^ cur_cfg_c.expected) & cur_cfg_c.mask) == '0;
  assign last_c    = (test_idx == IDX_W'(NUM_TESTS - 1));

  isa_test_watchdog #(
    .TIMEOUT_W      (TIMEOUT_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk       (clk),
    .reset     (reset),
    .clr       (state_q == START),
    .en        (state_q == WAIT),
    .expired_c (wd_expired_c)
  );

  // Configuration table; frozen while a run is in progress.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < int'(NUM_TESTS); i++) cfg_tbl[i] <= cfg_default();
    end else if (cfg_we && !busy) begin
      cfg_tbl[cfg_idx] <= '{en: cfg_en, expected: cfg_expected, mask: cfg_mask};
    end
  end

  // Next-state, verdict bookkeeping and registered-output next values.
  always_comb begin
    state_d       = state_q;
    idx_d         = test_idx;
    rst_cnt_d     = rst_cnt_q;
    run_done_d    = run_done;
    pass_vec_d    = pass_vec;
    fail_vec_d    = fail_vec;
    timeout_vec_d = timeout_vec;
    pass_cnt_d    = pass_count;
    fail_cnt_d    = fail_count;

    case (state_q)
      IDLE: begin
        if (go) begin
          state_d       = SKIP;
          idx_d         = '0;
          run_done_d    = 1'b0;
          pass_vec_d    = '0;
          fail_vec_d    = '0;
          timeout_vec_d = '0;
          pass_cnt_d    = '0;
          fail_cnt_d    = '0;
        end
      end
      SKIP: begin
        if (cur_cfg_c.en) begin
          state_d   = CRST;
          rst_cnt_d = RC_W'(RST_CYCLES - 1);
        end else begin
          state_d = NEXT;
        end
      end
      CRST: begin
        if (rst_cnt_q == '0) state_d = START;
        else                 rst_cnt_d = rst_cnt_q - RC_W'(1);
      end
      START: state_d = WAIT;
      WAIT: begin
        if (core_done) begin
          state_d = CHECK;
        end else if (wd_expired_c) begin
          timeout_vec_d[test_idx] = 1'b1;
          fail_vec_d[test_idx]    = 1'b1;
          fail_cnt_d              = fail_count + CNT_W'(1);
          state_d                 = FAIL_DEST;
        end
      end
      CHECK: begin
        if (match_c) begin
          pass_vec_d[test_idx] = 1'b1;
          pass_cnt_d           = pass_count + CNT_W'(1);
          state_d              = NEXT;
        end else begin
          fail_vec_d[test_idx] = 1'b1;
          fail_cnt_d           = fail_count + CNT_W'(1);
          state_d              = FAIL_DEST;
        end
      end
      NEXT: begin
        if (last_c) begin
          state_d = FIN;
        end else begin
          idx_d   = test_idx + IDX_W'(1);
          state_d = SKIP;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered against the state being entered.
    core_reset_d = (state_d == IDLE) || (state_d == CRST) || (state_d == FIN);
    core_start_d = (state_d == START);
    busy_d       = (state_d != IDLE) && (state_d != FIN);
    if (state_d == FIN) run_done_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      rst_cnt_q   <= '0;
      test_idx    <= '0;
      core_reset  <= 1'b1;
      core_start  <= 1'b0;
      busy        <= 1'b0;
      run_done    <= 1'b0;
      pass_vec    <= '0;
      fail_vec    <= '0;
      timeout_vec <= '0;
      pass_count  <= '0;
      fail_count  <= '0;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      test_idx    <= idx_d;
      core_reset  <= core_reset_d;
      core_start  <= core_start_d;
      busy        <= busy_d;
      run_done    <= run_done_d;
      pass_vec    <= pass_vec_d;
      fail_vec    <= fail_vec_d;
      timeout_vec <= timeout_vec_d;
      pass_count  <= pass_cnt_d;
      fail_count  <= fail_cnt_d;
    end
  end

endmodule

// File: tb/tb_isa_test_sequencer.sv
// Randomised and directed bench for isa_test_sequencer with a behavioural core and verdict model.
module tb_isa_test_sequencer;

  localparam int unsigned NT = 8;
  localparam int unsigned DW = 8;
  localparam int unsigned TW = 16;
  localparam int unsigned TC = 20;
  localparam int unsigned RC = 2;
  localparam int unsigned IW = 3;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          go = 1'b0;
  logic          cfg_we = 1'b0;
  logic [IW-1:0] cfg_idx = '0;
  logic          cfg_en = 1'b0;
  logic [DW-1:0] cfg_expected = '0;
  logic [DW-1:0] cfg_mask = '0;
  logic          core_reset, core_start, core_done;
  logic [IW-1:0] test_idx;
  logic [DW-1:0] obs_data;
  logic          busy, run_done;
  logic [NT-1:0] pass_vec, fail_vec, timeout_vec;
  logic [CW-1:0] pass_count, fail_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  isa_test_sequencer #(
    .NUM_TESTS(NT), .DATA_W(DW), .TIMEOUT_W(TW), .TIMEOUT_CYCLES(TC), .RST_CYCLES(RC)
  ) dut (
    .clk(clk), .reset(reset), .go(go), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_en(cfg_en), .cfg_expected(cfg_expected), .cfg_mask(cfg_mask),
    .core_reset(core_reset), .core_start(core_start), .core_done(core_done),
    .test_idx(test_idx), .obs_data(obs_data), .busy(busy), .run_done(run_done),
    .pass_vec(pass_vec), .fail_vec(fail_vec), .timeout_vec(timeout_vec),
    .pass_count(pass_count), .fail_count(fail_count)
  );

  // Behavioural core: done appears in WAIT cycle lat+1 after start; lat 0 never finishes.
  logic [DW-1:0] core_val [NT];
  int            core_lat [NT];
  int            wcnt;
  logic          armed;

  always @(posedge clk) begin
    if (!reset || core_reset) begin
      core_done <= 1'b0; armed <= 1'b0; wcnt <= 0;
    end else if (core_start) begin
      armed <= 1'b1; wcnt <= 0; core_done <= 1'b0;
    end else if (armed && core_lat[test_idx] != 0 && !core_done) begin
      wcnt <= wcnt + 1;
      if (wcnt + 1 >= core_lat[test_idx]) core_done <= 1'b1;
    end
  end
  assign obs_data = core_val[test_idx];

  // Table contents the bench believes the DUT holds.
  logic          m_en   [NT];
  logic [DW-1:0] m_exp  [NT];
  logic [DW-1:0] m_mask [NT];

  // Protocol monitor; its statistics restart whenever run_id changes.
  int            run_id = 0;
  int            seen_id = 0;
  int            cyc_now = 0;
  int            t0 = 0;
  int            rst_run = 0;
  int            bad_pulse = 0;
  int            bad_rst = 0;
  int            dwell [NT];
  logic          prev_start = 1'b0;
  logic [IW-1:0] prev_idx = '0;
  logic [NT-1:0] start_mask = '0;

  always @(negedge clk) begin
    cyc_now++;
    if (run_id != seen_id) begin
      seen_id = run_id; start_mask = '0; bad_pulse = 0; bad_rst = 0;
      for (int i = 0; i < int'(NT); i++) dwell[i] = -1;
    end
    if (core_start) begin
      start_mask[test_idx] = 1'b1;
      if (prev_start) bad_pulse++;
      if (rst_run != int'(RC)) bad_rst++;
      t0 = cyc_now;
    end
    if (busy && test_idx != prev_idx) dwell[prev_idx] = cyc_now - t0;
    rst_run    = core_reset ? rst_run + 1 : 0;
    prev_start = core_start;
    prev_idx   = test_idx;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cfg_write(input int i, input logic en, input logic [DW-1:0] e,
                           input logic [DW-1:0] m, input bit upd);
    @(negedge clk);
    cfg_we = 1'b1; cfg_idx = IW'(i); cfg_en = en; cfg_expected = e; cfg_mask = m;
    @(negedge clk);
    cfg_we = 1'b0;
    if (upd) begin
      m_en[i] = en; m_exp[i] = e; m_mask[i] = m;
    end
  endtask

  task automatic set_slot(input int i, input logic en, input logic [DW-1:0] e,
                          input logic [DW-1:0] m, input logic [DW-1:0] val, input int lat);
    core_val[i] = val;
    core_lat[i] = lat;
    cfg_write(i, en, e, m, 1'b1);
  endtask

  task automatic clear_all();
    for (int i = 0; i < int'(NT); i++) set_slot(i, 1'b0, 8'h00, 8'hFF, 8'h00, 1);
  endtask

  // Verdicts from the slot list: walk the enabled slots in order.
  task automatic ref_model(output logic [NT-1:0] ep, output logic [NT-1:0] ef,
                           output logic [NT-1:0] et, output logic [NT-1:0] es,
                           output int pc, output int fc);
    ep = '0; ef = '0; et = '0; es = '0; pc = 0; fc = 0;
    for (int i = 0; i < int'(NT); i++) begin
      if (m_en[i]) begin
        es[i] = 1'b1;
        if (core_lat[i] == 0 || core_lat[i] > int'(TC) - 1) begin
          et[i] = 1'b1; ef[i] = 1'b1; fc++;
        end else if (((core_val[i] ^ m_exp[i]) & m_mask[i]) == '0) begin
          ep[i] = 1'b1; pc++;
        end else begin
          ef[i] = 1'b1; fc++;
        end
`ifdef ISA_TEST_STOP_ON_FAIL_EN
        if (ef[i]) break;
`endif
      end
    end
  endtask

  task automatic run_and_check(input string tag, output int cycles);
    logic [NT-1:0] ep, ef, et, es;
    int pc, fc;
    ref_model(ep, ef, et, es, pc, fc);
    run_id++;
    @(negedge clk); go = 1'b1;
    @(negedge clk); go = 1'b0;
    cycles = 1;
    while (!run_done && cycles < 3000) begin
      @(negedge clk);
      cycles++;
    end
    check({tag, "/run_done"}, 64'(run_done), 64'(1));
    check({tag, "/pass_vec"}, 64'(pass_vec), 64'(ep));
    check({tag, "/fail_vec"}, 64'(fail_vec), 64'(ef));
    check({tag, "/timeout_vec"}, 64'(timeout_vec), 64'(et));
    check({tag, "/pass_count"}, 64'(pass_count), 64'(pc));
    check({tag, "/fail_count"}, 64'(fail_count), 64'(fc));
    check({tag, "/busy"}, 64'(busy), 64'(0));
    check({tag, "/core_reset"}, 64'(core_reset), 64'(1));
    check({tag, "/start_slots"}, 64'(start_mask), 64'(es));
    check({tag, "/start_width"}, 64'(bad_pulse), 64'(0));
    check({tag, "/rst_width"}, 64'(bad_rst), 64'(0));
`ifndef ISA_TEST_STOP_ON_FAIL_EN
    for (int i = 0; i < int'(NT) - 1; i++)
      if (et[i]) check({tag, "/timeout_dwell"}, 64'(dwell[i]), 64'(TC + 2));
`endif
  endtask

  int cyc;

  initial begin
    for (int i = 0; i < int'(NT); i++) begin
      m_en[i] = 1'b0; m_exp[i] = '0; m_mask[i] = '1;
      core_val[i] = '0; core_lat[i] = 1; dwell[i] = -1;
    end

    repeat (3) @(negedge clk);
    check("rst/busy", 64'(busy), 64'(0));
    check("rst/core_reset", 64'(core_reset), 64'(1));
    check("rst/core_start", 64'(core_start), 64'(0));
    check("rst/run_done", 64'(run_done), 64'(0));
    check("rst/test_idx", 64'(test_idx), 64'(0));
    check("rst/vectors", 64'({pass_vec, fail_vec, timeout_vec}), 64'(0));
    check("rst/counts", 64'({pass_count, fail_count}), 64'(0));
    reset = 1'b1;

    // Zero enabled slots: each disabled slot costs two cycles.
    run_and_check("empty", cyc);
    check("empty/cycles", 64'(cyc), 64'(2 * NT + 1));

    set_slot(0, 1'b1, 8'h07, 8'hFF, 8'h07, 5);
    run_and_check("single", cyc);

    set_slot(1, 1'b1, 8'h03, 8'hFF, 8'h02, 3);
    set_slot(2, 1'b1, 8'h03, 8'hFF, 8'h03, 2);
    set_slot(3, 1'b1, 8'hBB, 8'hFF, 8'hBB, 4);
    run_and_check("four", cyc);

    core_lat[2] = 0;
    run_and_check("timeout", cyc);

    clear_all();
    set_slot(0, 1'b1, 8'h05, 8'h0F, 8'hF5, 2);
    set_slot(2, 1'b1, 8'h05, 8'h0F, 8'h15, 1);
    run_and_check("mask_skip", cyc);

    // Done in the same cycle the watchdog would expire, then one cycle too late.
    clear_all();
    set_slot(0, 1'b1, 8'h11, 8'hFF, 8'h11, TC - 1);
    set_slot(1, 1'b1, 8'h22, 8'hFF, 8'h22, TC);
    run_and_check("boundary", cyc);

    // Reset while slot1 is waiting on the core.
    clear_all();
    set_slot(0, 1'b1, 8'h07, 8'hFF, 8'h07, 3);
    set_slot(1, 1'b1, 8'h00, 8'hFF, 8'h00, 0);
    run_id++;
    @(negedge clk); go = 1'b1;
    @(negedge clk); go = 1'b0;
    cyc = 0;
    while (!start_mask[1] && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("abort/reached_slot1", 64'(start_mask[1]), 64'(1));
    repeat (3) @(negedge clk);
    check("abort/pre_pass_count", 64'(pass_count), 64'(1));
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("abort/busy", 64'(busy), 64'(0));
    check("abort/core_reset", 64'(core_reset), 64'(1));
    check("abort/run_done", 64'(run_done), 64'(0));
    check("abort/test_idx", 64'(test_idx), 64'(0));
    check("abort/vectors", 64'({pass_vec, fail_vec, timeout_vec}), 64'(0));
    check("abort/counts", 64'({pass_count, fail_count}), 64'(0));
    for (int i = 0; i < int'(NT); i++) begin
      m_en[i] = 1'b0; m_exp[i] = '0; m_mask[i] = '1;
    end

    // Reset cleared the table; a write attempted mid-run must be dropped.
    core_val[5] = 8'h00; core_lat[5] = 1;
    fork
      run_and_check("rerun", cyc);
      begin
        repeat (4) @(negedge clk);
        cfg_write(5, 1'b1, 8'h00, 8'hFF, 1'b0);
      end
    join
    check("rerun/cycles", 64'(cyc), 64'(2 * NT + 1));
    run_and_check("busy_write", cyc);

    for (int r = 0; r < 15; r++) begin
      for (int i = 0; i < int'(NT); i++) begin
        logic [DW-1:0] e, m, v;
        int sel, lat;
        e   = DW'($urandom);
        m   = ($urandom_range(0, 1) == 0) ? 8'hFF : DW'($urandom);
        v   = ($urandom_range(0, 2) == 0) ? DW'($urandom) : (e ^ (DW'($urandom) & ~m));
        sel = int'($urandom_range(0, 9));
        lat = (sel == 0) ? 0 : (sel == 1) ? int'(TC) - 1 : (sel == 2) ? int'(TC)
                                                                       : int'($urandom_range(1, 6));
        set_slot(i, ($urandom_range(0, 3) != 0), e, m, v, lat);
      end
      run_and_check($sformatf("rand%0d", r), cyc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
